// File: rtl/jtcps1_watch_pkg.sv
// Shared constants for the CPS1 debug watch path: log entry layout and
// source-index helpers used by the aggregator, logger and status-bus mux.
package jtcps1_watch_pkg;

  localparam int SRC_W   = 4;
  localparam int FRM_W   = 8;
  localparam int POS_W   = 9;
  localparam int ENTRY_W = SRC_W + FRM_W + 2 * POS_W;

  // Bit offsets of each field inside a log entry / dout
  localparam int HCNT_LSB = 0;
  localparam int VCNT_LSB = HCNT_LSB + POS_W;
  localparam int FRM_LSB  = VCNT_LSB + POS_W;
  localparam int SRC_LSB  = FRM_LSB + FRM_W;

  localparam int MAX_SRC = 1 << SRC_W;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [SRC_W-1:0] lowest_set(input logic [MAX_SRC-1:0] v);
    lowest_set = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = SRC_W'(i);
    end
  endfunction

endpackage

// File: rtl/jtcps1_watch_fifo.sv
// First-word fall-through FIFO for watch log entries; occupancy is tracked
// with an AW+1-bit count so full and empty are unambiguous.
module jtcps1_watch_fifo #(
  parameter int DW    = 30,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  assign do_pop  = pop & ~clr & ~empty;
  assign do_push = push & ~clr & (~full | do_pop);

  assign dout = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; stale words are never visible
  // because dout is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/jtcps1_watch_log.sv
// Watch-strobe logger: turns each rising edge of a watched source into a
// timestamped FIFO entry readable over the debug status bus.
module jtcps1_watch_log
  import jtcps1_watch_pkg::*;
#(
  parameter int W     = 14,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pxl_cen,
  input  logic               HB,
  input  logic               VB,
  input  logic [W-1:0]       ev_in,
  input  logic               rd,
  input  logic               clr,
  output logic [ENTRY_W-1:0] dout,
  output logic               empty,
  output logic               ovf,
  output logic [7:0]         drops,
  output logic [W-1:0]       seen
);

  logic             hb_l, vb_l;
  logic [POS_W-1:0] hcnt, vcnt;
  logic [FRM_W-1:0] frame;

  logic [W-1:0]       ev_l;
  logic [W-1:0]       ev_edge;
  logic [W-1:0]       pending;
  logic [W-1:0]       grant;
  logic [SRC_W-1:0]   grant_idx;
  logic               push;
  logic               full;
  logic               drop;
  logic [ENTRY_W-1:0] entry;

  // Raster position; blanking edges are judged on pxl_cen-sampled values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_l  <= 1'b0;
      vb_l  <= 1'b0;
      hcnt  <= '0;
      vcnt  <= '0;
      frame <= '0;
    end else if (pxl_cen) begin
      hb_l <= HB;
      vb_l <= VB;
      hcnt <= (hb_l & ~HB) ? '0 : hcnt + POS_W'(1);
      if (vb_l & ~VB)      vcnt <= '0;
      else if (~hb_l & HB) vcnt <= vcnt + POS_W'(1);
      if (~vb_l & VB) frame <= frame + FRM_W'(1);
    end
  end

  assign ev_edge   = ev_in & ~ev_l;
  assign grant     = pending & (~pending + W'(1));
  assign grant_idx = lowest_set(MAX_SRC'(pending));
  assign push      = |pending;
  assign drop      = push & full & ~rd;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    entry = '0;
    entry[SRC_LSB  +: SRC_W] = grant_idx;
    entry[FRM_LSB  +: FRM_W] = frame;
    entry[VCNT_LSB +: POS_W] = vcnt;
    entry[HCNT_LSB +: POS_W] = hcnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_l    <= '0;
      pending <= '0;
      seen    <= '0;
      ovf     <= 1'b0;
      drops   <= '0;
    end else begin
      // Tracks the input even during clr so a held level is not re-armed
      ev_l <= ev_in;
      if (clr) begin
        pending <= '0;
        seen    <= '0;
        ovf     <= 1'b0;
        drops   <= '0;
      end else begin
        pending <= (pending & ~grant) | ev_edge;
        seen    <= seen | ev_edge;
        if (drop) begin
          ovf <= 1'b1;
          if (drops != 8'hff) drops <= drops + 8'd1;
        end
      end
    end
  end

  jtcps1_watch_fifo #(
    .DW    (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .din   (entry),
    .pop   (rd),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_jtcps1_watch_log.sv
// Randomised and directed bench for jtcps1_watch_log against a queue-based
// reference model of the watch log.
module tb_jtcps1_watch_log;
  import jtcps1_watch_pkg::*;

  localparam int W     = 14;
  localparam int DEPTH = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               pxl_cen = 1'b0;
  logic               HB = 1'b0;
  logic               VB = 1'b0;
  logic [W-1:0]       ev_in = '0;
  logic               rd = 1'b0;
  logic               clr = 1'b0;
  logic [ENTRY_W-1:0] dout;
  logic               empty;
  logic               ovf;
  logic [7:0]         drops;
  logic [W-1:0]       seen;

  jtcps1_watch_log #(.W(W), .DEPTH(DEPTH), .AW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .pxl_cen (pxl_cen),
    .HB      (HB),
    .VB      (VB),
    .ev_in   (ev_in),
    .rd      (rd),
    .clr     (clr),
    .dout    (dout),
    .empty   (empty),
    .ovf     (ovf),
    .drops   (drops),
    .seen    (seen)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raster position, pending set, log queue, sticky flags
  int                 m_h, m_v, m_f;
  bit                 m_hbl, m_vbl;
  logic [W-1:0]       m_evl, m_pend, m_seen;
  bit                 m_ovf;
  int                 m_drops;
  logic [ENTRY_W-1:0] m_q[$];

  function automatic int lowest(input logic [W-1:0] v);
    for (int i = 0; i < W; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0; m_f = 0;
    m_hbl = 0; m_vbl = 0;
    m_evl = '0; m_pend = '0; m_seen = '0;
    m_ovf = 0; m_drops = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    logic [W-1:0]       e;
    logic [ENTRY_W-1:0] ent;
    int                 g;
    bit                 was_full, popped;
    e   = ev_in & ~m_evl;
    g   = lowest(m_pend);
    ent = {4'(g), 8'(m_f), 9'(m_v), 9'(m_h)};
    if (pxl_cen) begin
      if (m_hbl && !HB) m_h = 0; else m_h = (m_h + 1) % 512;
      if (m_vbl && !VB) m_v = 0; else if (!m_hbl && HB) m_v = (m_v + 1) % 512;
      if (!m_vbl && VB) m_f = (m_f + 1) % 256;
      m_hbl = HB; m_vbl = VB;
    end
    m_evl = ev_in;
    if (clr) begin
      m_q.delete();
      m_pend = '0; m_seen = '0; m_ovf = 0; m_drops = 0;
    end else begin
      was_full = (m_q.size() == DEPTH);
      popped   = 0;
      if (rd && m_q.size() > 0) begin
        void'(m_q.pop_front());
        popped = 1;
      end
      if (g >= 0) begin
        if (!was_full || popped) m_q.push_back(ent);
        else begin
          m_ovf = 1;
          if (m_drops < 255) m_drops++;
        end
        m_pend[g] = 1'b0;
      end
      m_pend |= e;
      m_seen |= e;
    end
  endtask

  task automatic compare_all();
    check("empty", empty, m_q.size() == 0);
    if (m_q.size() > 0) check("dout", dout, m_q[0]);
    check("ovf", ovf, m_ovf);
    check("drops", drops, m_drops);
    check("seen", seen, m_seen);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  int exp_src[16];

  initial begin
    model_reset();
    #12;
    check("rst_empty", empty, 1);
    check("rst_dout", dout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_drops", drops, 0);
    check("rst_seen", seen, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single event after 10 pixel clocks
    pxl_cen = 1'b1;
    repeat (10) tick();
    pxl_cen = 1'b0;
    ev_in = 14'h0020;
    tick();
    ev_in = '0;
    tick();
    check("se_empty", empty, 0);
    check("se_src", dout[SRC_LSB +: SRC_W], 5);
    check("se_hcnt", dout[HCNT_LSB +: POS_W], 10);
    check("se_seen", seen, 14'h0020);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("se_pop_empty", empty, 1);

    // Simultaneous edges drain in ascending order; held level is silent
    ev_in = 14'h0A01;
    repeat (8) tick();
    check("sim_src0", dout[SRC_LSB +: SRC_W], 0);
    rd = 1'b1;
    tick();
    check("sim_src9", dout[SRC_LSB +: SRC_W], 9);
    tick();
    check("sim_src11", dout[SRC_LSB +: SRC_W], 11);
    tick();
    check("sim_empty", empty, 1);
    rd = 1'b0;
    ev_in = '0;
    tick();

    // Overflow: 20 distinct edges with no reads
    for (int i = 0; i < 20; i++) begin
      ev_in = '0;
      ev_in[i % 14] = 1'b1;
      tick();
    end
    ev_in = '0;
    repeat (2) tick();
    check("ovf_flag", ovf, 1);
    check("ovf_drops", drops, 4);

    // Full FIFO: push and pop in the same cycle
    ev_in[7] = 1'b1;
    tick();
    ev_in = '0;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("fpp_drops", drops, 4);
    check("fpp_empty", empty, 0);
    for (int i = 0; i < 15; i++) exp_src[i] = (i + 1) % 14;
    exp_src[15] = 7;
    rd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_src", dout[SRC_LSB +: SRC_W], exp_src[i]);
      tick();
    end
    rd = 1'b0;
    check("drain_empty", empty, 1);

    // Raster timestamp: frame 3, line 100, pixel 37
    pxl_cen = 1'b1;
    HB = 1'b1;
    for (int k = 0; k < 3; k++) begin
      VB = 1'b1; tick();
      VB = 1'b0; tick();
    end
    begin : raster
      for (int ln = 0; ln <= 100; ln++) begin
        for (int px = 0; px < 512; px++) begin
          HB = (px >= 448);
          tick();
          if (ln == 100 && px == 37) disable raster;
        end
      end
    end
    HB = 1'b0;
    ev_in[3] = 1'b1;
    tick();
    ev_in = '0;
    tick();
    check("tim_src", dout[SRC_LSB +: SRC_W], 3);
    check("tim_frame", dout[FRM_LSB +: FRM_W], 3);
    check("tim_vcnt", dout[VCNT_LSB +: POS_W], 100);
    check("tim_hcnt_win", (dout[HCNT_LSB +: POS_W] >= 37) && (dout[HCNT_LSB +: POS_W] <= 37 + W), 1);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    pxl_cen = 1'b0;

    // clr with five entries stored and sources 0,1 pending
    for (int i = 4; i <= 8; i++) begin
      ev_in = '0;
      ev_in[i] = 1'b1;
      tick();
    end
    ev_in = 14'h0003;
    tick();
    check("clr_pre_ovf", ovf, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_empty", empty, 1);
    check("clr_ovf", ovf, 0);
    check("clr_drops", drops, 0);
    check("clr_seen", seen, 0);
    repeat (3) tick();
    check("clr_held_empty", empty, 1);
    ev_in = '0;
    tick();

    // Asynchronous reset between clock edges
    ev_in[2] = 1'b1;
    tick();
    ev_in = '0;
    tick();
    check("arst_pre_empty", empty, 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_empty", empty, 1);
    check("arst_dout", dout, 0);
    check("arst_ovf", ovf, 0);
    check("arst_drops", drops, 0);
    check("arst_seen", seen, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Random traffic: light reads first (overflow), then heavy reads
    for (int n = 0; n < 4000; n++) begin
      pxl_cen = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) HB = ~HB;
      if ($urandom_range(0, 63) == 0) VB = ~VB;
      ev_in ^= W'($urandom & $urandom & $urandom);
      rd  = (n < 2000) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 299) == 0);
      tick();
    end
    clr = 1'b0;
    rd  = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
